// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared types for the dispatch controller
package dispatch_pkg;
    typedef enum logic {RUN, DRAIN} state_t;
endpackage

// File: rtl/outstanding_fifo.sv
// outstanding_fifo: in-order queue of granted queue ids awaiting completion
module outstanding_fifo #(
    parameter int ID_W  = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ID_W-1:0]          din,
    input  logic                     pop,
    output logic [ID_W-1:0]          head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ID_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr;
    logic [PW-1:0]   rd;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head = mem[rd];

    // storage needs no reset; only pointers define validity
    always_ff @(posedge clock) begin
        if (push) mem[wr] <= din;
    end

    // pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clock) begin
        if (reset) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= nxt(wr);
            if (pop) rd <= nxt(rd);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/dispatch_controller.sv
// dispatch_controller: policy-selected grant issue with multiple outstanding, in-order retire and watchdog
module dispatch_controller
    import dispatch_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES   = 4,
    parameter int NUMBER_OF_POLICIES = 7,
    parameter int MAX_OUTSTANDING    = 4,
    parameter int REGISTER_SIZE      = 32,
    localparam int ID_W   = $clog2(NUMBER_OF_QUEUES),
    localparam int MODE_W = $clog2(NUMBER_OF_POLICIES)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [MODE_W-1:0]             mode,
    input  logic [NUMBER_OF_QUEUES-1:0]   empty,
    input  logic [ID_W-1:0]               selections [NUMBER_OF_POLICIES],
    input  logic [NUMBER_OF_POLICIES-1:0] valids,
    input  logic                          consumed,
    input  logic [REGISTER_SIZE-1:0]      timeout_cycles,
    output logic [ID_W-1:0]               id,
    output logic                          enable,
    output logic [NUMBER_OF_QUEUES-1:0]   hasBeenConsumed,
    output logic                          timeout,
    output logic [MODE_W-1:0]             active_mode,
    output logic                          busy
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    state_t                      state;
    logic                        consumed_ff;
    logic                        rise;
    logic                        retire;
    logic                        expire;
    logic                        pop;
    logic                        grant;
    logic                        vld;
    logic [ID_W-1:0]             sel;
    logic [ID_W-1:0]             head;
    logic [CW-1:0]               count;
    logic [CW-1:0]               count_next;
    logic [NUMBER_OF_QUEUES-1:0] inflight;
    logic [REGISTER_SIZE-1:0]    wd;

    // out-of-range active_mode matches no policy, so it reads as invalid
    always_comb begin
        sel = '0;
        vld = 1'b0;
        for (int i = 0; i < NUMBER_OF_POLICIES; i++) begin
            if (active_mode == MODE_W'(i)) begin
                sel = selections[i];
                vld = valids[i];
            end
        end
    end

    assign rise            = consumed & ~consumed_ff;
    assign retire          = rise && count != '0;
    assign expire          = timeout_cycles != '0 && count != '0 && wd == timeout_cycles - REGISTER_SIZE'(1) && !rise;
    assign pop             = retire || expire;
    assign grant           = state == RUN && mode == active_mode && vld && !empty[sel] && !inflight[sel] && count < CW'(MAX_OUTSTANDING);
    assign count_next      = count + CW'(grant) - CW'(pop);
    assign hasBeenConsumed = retire ? NUMBER_OF_QUEUES'(1) << head : '0;

    outstanding_fifo #(
        .ID_W  (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (grant),
        .din   (sel),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    // grant outputs, inflight mask, edge detect and head watchdog
    always_ff @(posedge clock) begin
        if (reset) begin
            consumed_ff <= 1'b1;
            inflight    <= '0;
            wd          <= '0;
            id          <= '0;
            enable      <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            consumed_ff <= consumed;
            inflight    <= (inflight & ~(pop ? NUMBER_OF_QUEUES'(1) << head : '0)) | (grant ? NUMBER_OF_QUEUES'(1) << sel : '0);
            wd          <= (pop || count == '0) ? '0 : wd + REGISTER_SIZE'(1);
            id          <= grant ? sel : id;
            enable      <= grant;
            timeout     <= expire;
            busy        <= count_next != '0;
        end
    end

    // mode switches wait for all outstanding grants to retire
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            active_mode <= '0;
        end else if (state == RUN) begin
            if (mode != active_mode) state <= DRAIN;
        end else if (mode == active_mode) begin
            state <= RUN;
        end else if (count == '0) begin
            state       <= RUN;
            active_mode <= mode;
        end
    end
endmodule

// File: doc/dispatch_controller.md
# dispatch_controller

Parametrised successor to the single-outstanding dispatch control inside the MemorEDF scheduler. It takes the selection/valid pairs of all policy engines, picks the active policy, and grants queues with up to MAX_OUTSTANDING transactions in flight. Completions retire grants in order, and a watchdog retires a stuck grant. Mode changes take effect only after the block drains, so no policy switch happens with grants in flight.

## Interface
Parameters:
- NUMBER_OF_QUEUES, 4, queue count; ID_W = $clog2(NUMBER_OF_QUEUES)
- NUMBER_OF_POLICIES, 7, policy engines feeding the block; MODE_W = $clog2(NUMBER_OF_POLICIES)
- MAX_OUTSTANDING, 4, in-flight grant depth, power of two, >= 1
- REGISTER_SIZE, 32, width of timeout_cycles and the watchdog counter

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- mode  in  MODE_W  requested policy index
- empty  in  NUMBER_OF_QUEUES  per-queue empty flags
- selections  in  [NUMBER_OF_POLICIES][ID_W]  per-policy selected queue
- valids  in  NUMBER_OF_POLICIES  per-policy selection valid
- consumed  in  1  level; each rising edge is one completion
- timeout_cycles  in  REGISTER_SIZE  watchdog limit; 0 disables the watchdog
- id  out  ID_W  last granted queue
- enable  out  1  one-cycle grant pulse
- hasBeenConsumed  out  NUMBER_OF_QUEUES  one-hot completion pulse
- timeout  out  1  one-cycle pulse on watchdog retire
- active_mode  out  MODE_W  policy currently in force
- busy  out  1  at least one grant outstanding

## Operation
- Edge detect: rise = consumed & ~consumed_ff. consumed_ff resets to 1, so consumed held high through reset is not counted.
- Candidate: sel = selections[active_mode]. A grant is issued when all of the following hold:
  - state == RUN
  - valids[active_mode] is set
  - empty[sel] is clear
  - inflight[sel] is clear
  - count < MAX_OUTSTANDING
- Grant actions: push sel into the outstanding FIFO, set inflight[sel], register id <= sel, pulse enable.
- Each queue holds at most one outstanding grant. This avoids granting against a stale empty flag.
- rise with FIFO non-empty: pop the head h, clear inflight[h], hasBeenConsumed = one-hot(h). hasBeenConsumed is combinational in the same cycle as rise.
- rise with FIFO empty: ignored; no pulse, no state change.
- Watchdog:
  - Counts cycles the current head has been outstanding.
  - When timeout_cycles != 0 and the counter reaches timeout_cycles - 1 with no rise in that cycle: pop the head, clear its inflight bit, pulse timeout next cycle, no hasBeenConsumed.
  - The counter clears on every pop, and when the FIFO is empty.
- FSM state_t, two states:
  - RUN -> DRAIN when mode != active_mode. No grant is issued in the detecting cycle.
  - DRAIN blocks grants. DRAIN -> RUN when count == 0; active_mode <= mode in that transition.
  - If mode reverts to active_mode during DRAIN, return to RUN at the next cycle (no count wait).
- Out-of-range mode (>= NUMBER_OF_POLICIES) is adopted normally; it is treated as valid = 0, so no grants are issued.
- Grant and pop in the same cycle: both happen, count unchanged. A queue retired this cycle is not re-granted until the next cycle, because inflight is registered.
- Arithmetic: count is $clog2(MAX_OUTSTANDING)+1 bits. FIFO pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Reset values: id=0, enable=0, hasBeenConsumed=0, timeout=0, active_mode=0, busy=0, state=RUN, count=0, inflight=0.
- Grant latency: enable and id are registered, 1 cycle after the grant conditions hold. Back-to-back grants to distinct queues are possible every cycle.
- hasBeenConsumed: 0-cycle latency from the rising edge of consumed.
- busy: registered from the next-state count.
- timeout: asserted exactly timeout_cycles cycles after the head entered the head position.
- Reset mid-operation: FIFO, inflight, watchdog and FSM cleared next cycle; all outputs return to their reset values.

## Structure
- Package dispatch_pkg: state_t {RUN, DRAIN}; the width helpers ID_W and MODE_W are derived with localparams in the module.
- Sub-module outstanding_fifo: parametrised ID_W x MAX_OUTSTANDING. Ports push/pop/head/count; simultaneous push and pop legal when full.
- The parent holds the edge detect, FSM, inflight mask and watchdog.

## Test plan
- Reset with consumed=1, policy 0 valid, selections[0]=2, empty=0 -> enable pulses once with id=2 at cycle 1; no hasBeenConsumed while consumed stays high.
- MAX_OUTSTANDING=4; policy selects queues 0,1,2,3,0 on successive cycles -> four grants, fifth blocked (count=4); first rise -> hasBeenConsumed=4'b0001.
- Grants to queues 1 and 3 outstanding, mode 0->3 -> no grant during DRAIN; after two rises, active_mode=3 and grants resume one cycle later.
- timeout_cycles=10, grant to queue 2, no consumed -> timeout pulses 10 cycles later, busy falls, hasBeenConsumed stays 0.
- rise with nothing outstanding -> no outputs change; rise coinciding with a new grant -> count unchanged, in-order retire correct.
- mode=7 with NUMBER_OF_POLICIES=7 -> adopted after drain, no grants issued.
